// File: rtl/key_press_decoder.sv
// Push-button conditioner: 2-flop sync, per-key debounce FSM, registered press/release strobes.
// Optional auto-repeat of press while held is built when KEY_REPEAT_EN is defined.
module key_press_decoder #(
  parameter int unsigned N_KEYS          = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press,
  // `release` is a reserved word, so the release strobe carries the _o suffix
  output logic [N_KEYS-1:0] release_o,
  output logic              any_press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPressPend, StHeld, StRelPend} state_e;

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] pressed_nx, press_nx, release_nx;
  logic [N_KEYS-1:0] pressed_q, press_q, release_q;
  logic              any_press_q;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ~KEY;
      sync2_q <= sync1_q;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            press_fsm, rel_fsm, rep_fire;
    logic            s;

    assign s       = sync2_q[k];
    assign cnt_inc = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_fsm = 1'b0;
      rel_fsm   = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (s) begin
            state_d = StPressPend;
            cnt_d   = '0;
          end
        end
        StPressPend: begin
          if (!s) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == CntLast) begin
            state_d   = StHeld;
            press_fsm = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StHeld: begin
          if (!s) begin
            state_d = StRelPend;
            cnt_d   = '0;
          end
        end
        StRelPend: begin
          if (s) begin
            state_d = StHeld;
            cnt_d   = '0;
          end else if (cnt_q == CntLast) begin
            state_d = StIdle;
            rel_fsm = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

`ifdef KEY_REPEAT_EN
    localparam int unsigned RepMax =
        (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RepW = $clog2(RepMax + 1);
    localparam logic [RepW-1:0] DelayLast  = RepW'(REPEAT_DELAY - 1);
    localparam logic [RepW-1:0] PeriodLast = RepW'(REPEAT_PERIOD - 1);

    logic [RepW-1:0] rep_q, rep_d;
    logic            rep_first_q, rep_first_d;

    // Counts only while staying in HELD; REL_PEND pauses, IDLE/PRESS_PEND clear
    always_comb begin
      rep_d       = rep_q;
      rep_first_d = rep_first_q;
      rep_fire    = 1'b0;
      if (state_q == StHeld && s) begin
        if (rep_q == (rep_first_q ? PeriodLast : DelayLast)) begin
          rep_fire    = 1'b1;
          rep_d       = '0;
          rep_first_d = 1'b1;
        end else if (rep_q != {RepW{1'b1}}) begin
          rep_d = rep_q + RepW'(1);
        end
      end
      if (state_d == StIdle || state_d == StPressPend) begin
        rep_d       = '0;
        rep_first_d = 1'b0;
      end
    end

    always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
        rep_q       <= '0;
        rep_first_q <= 1'b0;
      end else begin
        rep_q       <= rep_d;
        rep_first_q <= rep_first_d;
      end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign press_nx[k]   = press_fsm | rep_fire;
    assign release_nx[k] = rel_fsm;
    assign pressed_nx[k] = (state_d == StHeld) || (state_d == StRelPend);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      pressed_q   <= '0;
      press_q     <= '0;
      release_q   <= '0;
      any_press_q <= 1'b0;
    end else begin
      pressed_q   <= pressed_nx;
      press_q     <= press_nx;
      release_q   <= release_nx;
      any_press_q <= |press_nx;
    end
  end

  assign pressed   = pressed_q;
  assign press     = press_q;
  assign release_o = release_q;
  assign any_press = any_press_q;

endmodule

// File: tb/tb_key_press_decoder.sv
// Directed bench for key_press_decoder (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
module tb_key_press_decoder;

  logic       CLOCK_50;
  logic       RESET;
  logic [2:0] KEY;
  logic [2:0] pressed, press, rel;
  logic       any_press;

  int checks   = 0;
  int failures = 0;

  key_press_decoder #(
    .N_KEYS         (3),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .KEY      (KEY),
    .pressed  (pressed),
    .press    (press),
    .release_o(rel),
    .any_press(any_press)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    KEY   = 3'b111;
    step();
    step();
    checks++;
    if ({pressed, press, rel, any_press} !== 10'b0) begin
      failures++;
      $display("FAIL reset_state: got %b expected 0", {pressed, press, rel, any_press});
    end
    RESET = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if ({pressed, press, rel, any_press} !== 10'b0) begin
        failures++;
        $display("FAIL reset_idle cyc %0d: got %b expected 0", i,
                 {pressed, press, rel, any_press});
      end
    end
  endtask

  task automatic test_clean_press();
    KEY = 3'b110;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (press !== ((i == 7) ? 3'b001 : 3'b000)) begin
        failures++;
        $display("FAIL clean_press cyc %0d: press=%b expected %b", i, press,
                 (i == 7) ? 3'b001 : 3'b000);
      end
      checks++;
      if (any_press !== (i == 7)) begin
        failures++;
        $display("FAIL clean_any cyc %0d: any_press=%b expected %b", i, any_press, (i == 7));
      end
      checks++;
      if (pressed !== ((i >= 7) ? 3'b001 : 3'b000)) begin
        failures++;
        $display("FAIL clean_pressed cyc %0d: pressed=%b", i, pressed);
      end
    end
    KEY = 3'b111;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (rel !== ((i == 7) ? 3'b001 : 3'b000) || press !== 3'b000) begin
        failures++;
        $display("FAIL clean_release cyc %0d: release=%b press=%b", i, rel, press);
      end
      checks++;
      if (pressed !== ((i < 7) ? 3'b001 : 3'b000)) begin
        failures++;
        $display("FAIL clean_rel_pressed cyc %0d: pressed=%b", i, pressed);
      end
    end
  endtask

  task automatic test_bounce();
    KEY = 3'b101;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) KEY = 3'b111;
      step();
      checks++;
      if (press !== 3'b000 || rel !== 3'b000 || pressed !== 3'b000) begin
        failures++;
        $display("FAIL bounce_glitch cyc %0d: press=%b release=%b pressed=%b", i, press, rel,
                 pressed);
      end
    end
    KEY = 3'b101;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (press !== ((i == 7) ? 3'b010 : 3'b000) || rel !== 3'b000) begin
        failures++;
        $display("FAIL bounce_press cyc %0d: press=%b release=%b expected press %b", i, press,
                 rel, (i == 7) ? 3'b010 : 3'b000);
      end
    end
    KEY = 3'b111;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (rel !== ((i == 7) ? 3'b010 : 3'b000)) begin
        failures++;
        $display("FAIL bounce_release cyc %0d: release=%b", i, rel);
      end
    end
  endtask

  task automatic test_simultaneous();
    KEY = 3'b000;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (press !== ((i == 7) ? 3'b111 : 3'b000) || any_press !== (i == 7)) begin
        failures++;
        $display("FAIL simul_press cyc %0d: press=%b any_press=%b", i, press, any_press);
      end
    end
    KEY = 3'b111;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (rel !== ((i == 7) ? 3'b111 : 3'b000) || press !== 3'b000) begin
        failures++;
        $display("FAIL simul_release cyc %0d: release=%b press=%b", i, rel, press);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    KEY = 3'b110;
    for (int i = 1; i <= 3; i++) step();
    RESET = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      step();
      checks++;
      if ({pressed, press, rel, any_press} !== 10'b0) begin
        failures++;
        $display("FAIL reset_mid cyc %0d: got %b expected 0", i,
                 {pressed, press, rel, any_press});
      end
    end
    RESET = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (press !== ((i == 7) ? 3'b001 : 3'b000)) begin
        failures++;
        $display("FAIL reset_repress cyc %0d: press=%b expected %b", i, press,
                 (i == 7) ? 3'b001 : 3'b000);
      end
    end
    KEY = 3'b111;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (rel !== ((i == 7) ? 3'b001 : 3'b000)) begin
        failures++;
        $display("FAIL reset_release cyc %0d: release=%b", i, rel);
      end
    end
  endtask

  task automatic test_repeat();
    logic ep;
    KEY = 3'b110;
    for (int i = 1; i <= 35; i++) begin
      step();
      ep = (i == 7);
`ifdef KEY_REPEAT_EN
      if (i >= 17 && ((i - 17) % 3) == 0) ep = 1'b1;
`endif
      checks++;
      if (press !== {2'b00, ep}) begin
        failures++;
        $display("FAIL repeat_press cyc %0d: press=%b expected %b", i, press, {2'b00, ep});
      end
    end
    KEY = 3'b111;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (press !== 3'b000 || rel !== ((i == 7) ? 3'b001 : 3'b000)) begin
        failures++;
        $display("FAIL repeat_release cyc %0d: press=%b release=%b", i, press, rel);
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    KEY   = 3'b111;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_debounce();
    test_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
